// File: rtl/branch_predictor.sv
// branch_predictor: dynamic branch/jump predictor for the IF stage.
//   Direct-mapped BTB (flop storage) with per-entry saturating counters, looked up
//   combinationally with the fetch PC and trained by branches/jumps resolved in EX.
//   Optional return-address stack enabled by defining BP_RAS_EN.
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   if_pc                PC being fetched
//   pred_taken           predict redirect this cycle
//   pred_target          predicted target if pred_taken, else if_pc+4
//   upd_valid            EX resolved a branch/jump this cycle
//   upd_pc/upd_taken     PC and actual outcome of the resolved instruction
//   upd_target           actual target
//   upd_is_branch        1 = conditional branch, 0 = unconditional jump
//   if_is_ret            predecode: fetched instruction is jr $31
//   ras_push/_addr       predecode: call fetched, push its return address
//   ras_pop              return consumed
module branch_predictor #(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned TAG_BITS  = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_is_branch,
  input  logic        if_is_ret,
  input  logic        ras_push,
  input  logic [31:0] ras_push_addr,
  input  logic        ras_pop
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX + 2;
  localparam int unsigned TAG_HI = IDX + 1 + TAG_BITS;

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  // Weakly not-taken is all ones below the MSB; weakly taken is MSB alone.
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_MAX >> 1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = ~CTR_WNT;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [IDX-1:0]      if_idx, upd_idx;
  logic [TAG_BITS-1:0] if_tag, upd_tag;
  logic                btb_taken, upd_hit;
  logic                ras_hit;
  logic [31:0]         ras_top;

  assign if_idx  = if_pc[IDX+1:2];
  assign if_tag  = if_pc[TAG_HI:TAG_LO];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[TAG_HI:TAG_LO];

  assign btb_taken = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && ctr_q[if_idx][CTR_BITS-1];
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[1:0], upd_pc[31:TAG_HI+1]};

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = if_pc + 32'd4;
    if (!rst) begin
      if (ras_hit) begin
        pred_taken  = 1'b1;
        pred_target = ras_top;
      end else if (btb_taken) begin
        pred_taken  = 1'b1;
        pred_target = target_q[if_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_is_branch) begin
          if (upd_taken) begin
            if (ctr_q[upd_idx] != CTR_MAX) ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_BITS'(1);
            target_q[upd_idx] <= upd_target;
          end else if (ctr_q[upd_idx] != '0) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_BITS'(1);
          end
        end else begin
          ctr_q[upd_idx]    <= CTR_MAX;
          target_q[upd_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= upd_is_branch ? CTR_WT : CTR_MAX;
      end
    end
  end

`ifdef BP_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [31:0]      ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q, ptr_inc, ptr_dec;
  logic [CNT_W-1:0] ras_cnt_q;

  // ras_ptr_q points at the current top; wrap explicitly so any depth works.
  assign ptr_inc = (ras_ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + PTR_W'(1);
  assign ptr_dec = (ras_ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr_q - PTR_W'(1);

  assign ras_hit = if_is_ret && (ras_cnt_q != '0);
  assign ras_top = ras_q[ras_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (ras_push && ras_pop && (ras_cnt_q != '0)) begin
      ras_q[ras_ptr_q] <= ras_push_addr;
    end else if (ras_push) begin
      // Overflow wraps the pointer onto the oldest entry; count saturates.
      ras_q[ptr_inc] <= ras_push_addr;
      ras_ptr_q      <= ptr_inc;
      if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + CNT_W'(1);
    end else if (ras_pop && (ras_cnt_q != '0)) begin
      ras_ptr_q <= ptr_dec;
      ras_cnt_q <= ras_cnt_q - CNT_W'(1);
    end
  end
`else
  assign ras_hit = 1'b0;
  assign ras_top = '0;

  logic unused_ras;
  assign unused_ras = ^{if_is_ret, ras_push, ras_push_addr, ras_pop, ras_top};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared against a behavioural model (arrays + queue).
module tb_branch_predictor;

  localparam int NENT = 64;
  localparam int RASD = 4;
`ifdef BP_RAS_EN
  localparam bit RasEn = 1'b1;
`else
  localparam bit RasEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_is_branch;
  logic [31:0] upd_pc, upd_target;
  logic        if_is_ret, ras_push, ras_pop;
  logic [31:0] ras_push_addr;

  int n_checks = 0;
  int n_pass   = 0;

  branch_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .if_pc        (if_pc),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .upd_is_branch(upd_is_branch),
    .if_is_ret    (if_is_ret),
    .ras_push     (ras_push),
    .ras_push_addr(ras_push_addr),
    .ras_pop      (ras_pop)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit          m_valid  [NENT];
  int unsigned m_tag    [NENT];
  logic [31:0] m_target [NENT];
  int          m_ctr    [NENT];
  logic [31:0] m_ras    [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [32:0] model_pred(input logic [31:0] pc, input bit ret);
    int unsigned i, t;
    i = (pc / 4) % NENT;
    t = (pc / 256) % 256;
    if (RasEn && ret && m_ras.size() > 0) return {1'b1, m_ras[m_ras.size() - 1]};
    if (m_valid[i] && m_tag[i] == t && m_ctr[i] >= 2) return {1'b1, m_target[i]};
    return {1'b0, pc + 32'd4};
  endfunction

  task automatic model_step();
    int unsigned i, t;
    if (rst) begin
      for (int k = 0; k < NENT; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
      m_ras.delete();
      return;
    end
    if (upd_valid) begin
      i = (upd_pc / 4) % NENT;
      t = (upd_pc / 256) % 256;
      if (m_valid[i] && m_tag[i] == t) begin
        if (!upd_is_branch) begin
          m_ctr[i]    = 3;
          m_target[i] = upd_target;
        end else if (upd_taken) begin
          m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = t;
        m_target[i] = upd_target;
        m_ctr[i]    = upd_is_branch ? 2 : 3;
      end
    end
    if (RasEn) begin
      if (ras_push && ras_pop && m_ras.size() > 0) begin
        m_ras[m_ras.size() - 1] = ras_push_addr;
      end else if (ras_push) begin
        m_ras.push_back(ras_push_addr);
        if (m_ras.size() > RASD) void'(m_ras.pop_front());
      end else if (ras_pop && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic tick(input string tag, input bit chk, input bit exp_t, input logic [31:0] exp_tgt);
    logic [32:0] e;
    #4;
    if (rst) e = {1'b0, if_pc + 32'd4};
    else e = model_pred(if_pc, if_is_ret);
    check({tag, ".model_taken"}, 32'(pred_taken), 32'(e[32]));
    check({tag, ".model_target"}, pred_target, e[31:0]);
    if (chk) begin
      check({tag, ".taken"}, 32'(pred_taken), 32'(exp_t));
      check({tag, ".target"}, pred_target, exp_tgt);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tgt, input bit br);
    upd_valid     = v;
    upd_pc        = pc;
    upd_taken     = tk;
    upd_target    = tgt;
    upd_is_branch = br;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return 32'h3000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
  endfunction

  initial begin
    rst = 1'b1;
    if_pc = 32'h3000;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    if_is_ret = 1'b0;
    ras_push = 1'b0;
    ras_pop = 1'b0;
    ras_push_addr = 32'h0;
    @(posedge clk);
    #1;

    tick("reset0", 1'b1, 1'b0, 32'h3004);
    tick("reset1", 1'b1, 1'b0, 32'h3004);
    rst = 1'b0;
    tick("s1", 1'b1, 1'b0, 32'h3004);

    set_upd(1'b1, 32'h3010, 1'b1, 32'h3040, 1'b1);
    tick("s2_upd", 1'b1, 1'b0, 32'h3004);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    if_pc = 32'h3010;
    tick("s2_hit", 1'b1, 1'b1, 32'h3040);

    set_upd(1'b1, 32'h3010, 1'b0, 32'h3040, 1'b1);
    tick("s3_nt_c2", 1'b1, 1'b1, 32'h3040);
    tick("s3_nt_c1", 1'b1, 1'b0, 32'h3014);
    tick("s3_nt_c0", 1'b1, 1'b0, 32'h3014);
    set_upd(1'b1, 32'h3010, 1'b1, 32'h3040, 1'b1);
    tick("s3_t_c0", 1'b1, 1'b0, 32'h3014);
    tick("s3_t_c1", 1'b1, 1'b0, 32'h3014);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick("s3_c2", 1'b1, 1'b1, 32'h3040);

    if_pc = 32'h3110;
    set_upd(1'b1, 32'h3110, 1'b0, 32'h3200, 1'b1);
    tick("s4_tagmiss", 1'b1, 1'b0, 32'h3114);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    if_pc = 32'h3010;
    tick("s4_kept", 1'b1, 1'b1, 32'h3040);

    set_upd(1'b1, 32'h3010, 1'b1, 32'h3080, 1'b1);
    tick("s5_same", 1'b1, 1'b1, 32'h3040);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick("s5_next", 1'b1, 1'b1, 32'h3080);

    if_pc = 32'h3020;
    set_upd(1'b1, 32'h3020, 1'b1, 32'h3400, 1'b0);
    tick("jmp_alloc", 1'b1, 1'b0, 32'h3024);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick("jmp_hit", 1'b1, 1'b1, 32'h3400);

    rst = 1'b1;
    if_pc = 32'h3010;
    set_upd(1'b1, 32'h3010, 1'b1, 32'h3100, 1'b0);
    tick("s5_rst", 1'b1, 1'b0, 32'h3014);
    rst = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick("s5_after_rst", 1'b1, 1'b0, 32'h3014);
    if_pc = 32'h3020;
    tick("s5_after_rst2", 1'b1, 1'b0, 32'h3024);

    if_pc = 32'hFFFF_FFFC;
    tick("wrap", 1'b1, 1'b0, 32'h0000_0000);

    if_pc = 32'h3500;
`ifdef BP_RAS_EN
    ras_push = 1'b1;
    ras_push_addr = 32'h3008;
    tick("ras_push1", 1'b0, 1'b0, 32'h0);
    ras_push_addr = 32'h3020;
    tick("ras_push2", 1'b0, 1'b0, 32'h0);
    ras_push = 1'b0;
    if_is_ret = 1'b1;
    ras_pop = 1'b1;
    tick("ras_ret1", 1'b1, 1'b1, 32'h3020);
    tick("ras_ret2", 1'b1, 1'b1, 32'h3008);
    tick("ras_empty", 1'b1, 1'b0, 32'h3504);
    if_is_ret = 1'b0;
    ras_pop = 1'b0;
    ras_push = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ras_push_addr = 32'h4000 + 32'(4 * k);
      tick("ras_fill", 1'b0, 1'b0, 32'h0);
    end
    ras_push = 1'b0;
    if_is_ret = 1'b1;
    ras_pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick("ras_ovf", 1'b1, 1'b1, 32'h4010 - 32'(4 * k));
    end
    tick("ras_drained", 1'b1, 1'b0, 32'h3504);
`else
    ras_push = 1'b1;
    ras_push_addr = 32'h3008;
    tick("noras_push", 1'b0, 1'b0, 32'h0);
    ras_push = 1'b0;
    if_is_ret = 1'b1;
    ras_pop = 1'b1;
    tick("noras_ret", 1'b1, 1'b0, 32'h3504);
`endif
    if_is_ret = 1'b0;
    ras_pop = 1'b0;

    for (int n = 0; n < 800; n++) begin
      rst           = ($urandom_range(0, 79) == 0);
      if_pc         = rand_pc();
      if_is_ret     = ($urandom_range(0, 3) == 0);
      ras_push      = ($urandom_range(0, 3) == 0);
      ras_pop       = ($urandom_range(0, 3) == 0);
      ras_push_addr = $urandom() & 32'hFFFF_FFFC;
      set_upd($urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 2) != 0,
              $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0);
      tick("rnd", 1'b0, 1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
